country_road_ctrl: RTL and testbench
====================================

Name: country_road_ctrl

Overview:
Country-road side of the highway/country-road intersection controller. Synchronises and debounces the raw country-road car sensor, and drives the one-hot country light out_c. out_c and the debounced request feed the highway light FSM. The block also consumes that FSM's one-hot out_h and only gives green while the highway shows red. A sticky conflict flag forces the country road to red.

Parameters:
DEB_LEN, 4, consecutive synchronised cycles a new sensor level must hold before car_req follows it (>=1)
MIN_G, 5, minimum country green duration in cycles (>=1)
MAX_G, 15, maximum country green duration in cycles (>=MIN_G)
Y_T, 3, country yellow duration in cycles (>=1)
CNT_W, 5, width of internal counters; must hold max(DEB_LEN, MAX_G, Y_T)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
sensor_c  input  1  raw asynchronous car-present sensor, country road
out_h  input  3  highway light, one-hot: 001 green, 010 yellow, 100 red
car_req  output  1  synchronised, debounced sensor; feeds the highway FSM sensor input
out_c  output  3  country light, one-hot registered: 001 green, 010 yellow, 100 red
conflict  output  1  sticky error: out_h not red while out_c green/yellow

Behaviour:
- Reset (async, any time incl. mid-green): out_c=100, car_req=0, conflict=0, FSM=C_RED, all counters 0, armed=0, sync flops 0.
- Sync: 2-flop synchroniser on sensor_c -> s_sync.
- Debounce: deb_cnt clears when s_sync==car_req. Otherwise it increments. On the edge where s_sync!=car_req and deb_cnt==DEB_LEN-1, car_req<=s_sync and deb_cnt<=0.
- Debounce latency: a clean step on sensor_c reaches car_req 2+DEB_LEN edges later. Pulses shorter than DEB_LEN synchronised cycles are ignored, both rising and falling.
- armed flag: set on any edge with out_h!=100 and cleared on the C_YELLOW->C_RED transition. This prevents re-entering green while the highway is still red from the previous cycle.
- All outputs are registered. out_c decodes state: C_RED=100, C_GREEN=001, C_YELLOW=010.
- C_RED: if armed and out_h==100, go to C_GREEN with cnt=0. out_c=001 after the next edge, one-cycle latency from out_h turning red. Otherwise stay; cnt held 0.
- C_GREEN: cnt increments each edge. Go to C_YELLOW with cnt=0 when (cnt>=MIN_G-1 and car_req==0) or cnt==MAX_G-1. Green is visible for MIN_G..MAX_G cycles.
- C_YELLOW: cnt increments. At cnt==Y_T-1, go to C_RED with cnt=0 and armed=0. Yellow is visible for exactly Y_T cycles.
- Conflict: on any edge in C_GREEN or C_YELLOW with out_h!=100, set conflict=1 and force C_RED, cnt=0, armed=0. This overrides all other transitions.
  - conflict stays 1 until reset.
  - While conflict=1 the FSM is held in C_RED regardless of out_h.
- out_h non-one-hot (e.g. 000, 011) counts as "not red" for armed and for conflict.
- Green exit has priority: when MAX_G-1 and car_req rising coincide, go to yellow anyway.
- Counters never wrap: the FSM exits before cnt reaches 2^CNT_W-1 given legal parameters.

Test Plan:
- Reset then out_h=001, sensor_c=0 for 50 cycles -> out_c=100, car_req=0, conflict=0 throughout.
- sensor_c 0->1 clean step (DEB_LEN=4) -> car_req rises exactly 6 edges later. 3-cycle high glitch -> car_req stays 0.
- out_h 001->100 at edge E0, car_req held 1 -> out_c=001 after E1. Green lasts 15 cycles (MAX_G), then 010 for 3 cycles, then 100. out_h kept 100 -> no second green until out_h leaves 100 and returns.
- car_req drops at green cycle 2 -> yellow starts after green cycle 5 (MIN_G). car_req drops at cycle 8 -> yellow after cycle 8.
- out_h forced to 001 during country green -> next edge out_c=100, conflict=1. A later out_h=100 never produces green until reset.
- reset asserted mid-yellow between edges -> out_c=100, car_req=0 immediately. Normal cycle resumes after release.

Source files
------------

// File: rtl/country_road_ctrl_if.sv
// rtl/country_road_ctrl_if.sv - country-road controller signal bundle
interface country_road_ctrl_if;
   logic       sensor_c;
   logic [2:0] out_h;
   logic       car_req;
   logic [2:0] out_c;
   logic       conflict;

   modport master (
      output sensor_c,
      output out_h,
      input  car_req,
      input  out_c,
      input  conflict
   );

   modport slave (
      input  sensor_c,
      input  out_h,
      output car_req,
      output out_c,
      output conflict
   );
endinterface

// File: rtl/country_road_ctrl.sv
// rtl/country_road_ctrl.sv - country-road light: sensor sync/debounce, light FSM, conflict guard
module country_road_ctrl #(
   parameter int DEB_LEN = 4,
   parameter int MIN_G   = 5,
   parameter int MAX_G   = 15,
   parameter int Y_T     = 3,
   parameter int CNT_W   = 5
) (
   input logic                 clk,
   input logic                 reset,
   country_road_ctrl_if.slave  bus
);
   localparam logic [1:0] C_RED    = 2'd0;
   localparam logic [1:0] C_GREEN  = 2'd1;
   localparam logic [1:0] C_YELLOW = 2'd2;

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_LEN - 1);
   localparam logic [CNT_W-1:0] G_MIN_LAST = CNT_W'(MIN_G - 1);
   localparam logic [CNT_W-1:0] G_MAX_LAST = CNT_W'(MAX_G - 1);
   localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(Y_T - 1);

   logic             s_meta;
   logic             s_sync;
   logic [CNT_W-1:0] deb_cnt;
   logic             car_req_q;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             armed;
   logic             armed_nxt;
   logic             conflict_q;
   logic             conflict_nxt;
   logic [2:0]       out_c_q;
   logic [2:0]       out_c_nxt;
   logic             h_red;

   // Anything other than exactly one-hot red is treated as highway not red.
   assign h_red = (bus.out_h == 3'b100);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_meta    <= 1'b0;
         s_sync    <= 1'b0;
         deb_cnt   <= '0;
         car_req_q <= 1'b0;
      end else begin
         s_meta <= bus.sensor_c;
         s_sync <= s_meta;
         if (s_sync == car_req_q) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            car_req_q <= s_sync;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      armed_nxt    = armed | ~h_red;
      conflict_nxt = conflict_q;
      case (state)
         C_RED: begin
            cnt_nxt = '0;
            if (!conflict_q && armed && h_red) begin
               state_nxt = C_GREEN;
            end
         end
         C_GREEN: begin
            cnt_nxt = cnt + 1'b1;
            if ((cnt >= G_MIN_LAST && !car_req_q) || cnt == G_MAX_LAST) begin
               state_nxt = C_YELLOW;
               cnt_nxt   = '0;
            end
         end
         C_YELLOW: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == Y_LAST) begin
               state_nxt = C_RED;
               cnt_nxt   = '0;
               armed_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = C_RED;
            cnt_nxt   = '0;
         end
      endcase
      // A non-red highway while we show green/yellow overrides everything else.
      if (state != C_RED && !h_red) begin
         conflict_nxt = 1'b1;
         state_nxt    = C_RED;
         cnt_nxt      = '0;
         armed_nxt    = 1'b0;
      end
   end

   always_comb begin
      out_c_nxt = 3'b100;
      case (state_nxt)
         C_GREEN:  out_c_nxt = 3'b001;
         C_YELLOW: out_c_nxt = 3'b010;
         default:  out_c_nxt = 3'b100;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= C_RED;
         cnt        <= '0;
         armed      <= 1'b0;
         conflict_q <= 1'b0;
         out_c_q    <= 3'b100;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         armed      <= armed_nxt;
         conflict_q <= conflict_nxt;
         out_c_q    <= out_c_nxt;
      end
   end

   assign bus.car_req  = car_req_q;
   assign bus.out_c    = out_c_q;
   assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_country_road_ctrl.sv
// tb/tb_country_road_ctrl.sv - scoreboard bench for country_road_ctrl
module tb_country_road_ctrl;
   localparam int DEB_LEN = 4;
   localparam int MIN_G   = 5;
   localparam int MAX_G   = 15;
   localparam int Y_T     = 3;
   localparam int CNT_W   = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   country_road_ctrl_if bus ();

   country_road_ctrl #(
      .DEB_LEN(DEB_LEN), .MIN_G(MIN_G), .MAX_G(MAX_G), .Y_T(Y_T), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [2:0] out_c;
      logic       car_req;
      logic       conflict;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   // Reference model: phases 0 red, 1 green, 2 yellow; m_len = cycles already spent in phase.
   bit raw[$];
   bit ss[$];
   bit m_car_req, m_armed, m_conflict;
   int m_phase, m_len;

   function automatic logic [2:0] light(input int ph);
      return (ph == 1) ? 3'b001 : (ph == 2) ? 3'b010 : 3'b100;
   endfunction

   task automatic model_reset();
      raw.delete();
      ss.delete();
      raw.push_back(1'b0);
      raw.push_back(1'b0);
      for (int i = 0; i < DEB_LEN; i++) ss.push_back(1'b0);
      m_car_req = 0; m_armed = 0; m_conflict = 0; m_phase = 0; m_len = 0;
   endtask

   task automatic model_edge(input bit s, input logic [2:0] h);
      bit   hr, flip, na, nc;
      int   np, nl;
      exp_t e;
      hr = (h == 3'b100);
      raw.push_back(s);
      ss.push_back(raw[raw.size()-3]);
      if (raw.size() > 8) void'(raw.pop_front());
      if (ss.size() > DEB_LEN + 4) void'(ss.pop_front());
      // car_req flips once the synchronised level has disagreed with it for DEB_LEN edges
      flip = 1;
      for (int i = 0; i < DEB_LEN; i++) if (ss[ss.size()-1-i] == m_car_req) flip = 0;
      na = m_armed | !hr; nc = m_conflict; np = m_phase; nl = m_len + 1;
      if (m_phase != 0 && !hr) begin
         nc = 1; np = 0; nl = 0; na = 0;
      end else if (m_phase == 0) begin
         nl = 0;
         if (!m_conflict && m_armed && hr) np = 1;
      end else if (m_phase == 1) begin
         if ((m_len + 1 >= MIN_G && !m_car_req) || m_len + 1 == MAX_G) begin np = 2; nl = 0; end
      end else if (m_len + 1 == Y_T) begin
         np = 0; nl = 0; na = 0;
      end
      m_phase = np; m_len = nl; m_armed = na; m_conflict = nc;
      if (flip) m_car_req = !m_car_req;
      e.out_c = light(m_phase); e.car_req = m_car_req; e.conflict = m_conflict;
      exp_q.push_back(e);
   endtask

   task automatic apply(input bit s, input logic [2:0] h);
      bus.sensor_c = s;
      bus.out_h    = h;
      model_edge(s, h);
   endtask

   task automatic step(input bit s, input logic [2:0] h);
      @(negedge clk);
      apply(s, h);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_out_c", bus.out_c, e.out_c);
            check("sb_car_req", bus.car_req, e.car_req);
            check("sb_conflict", bus.conflict, e.conflict);
         end
      end
   end

   task automatic do_reset(input bit from_idle);
      reset = 1'b1;
      if (from_idle) repeat (2) @(posedge clk);
      #1;
      check("rst_out_c", bus.out_c, 3'b100);
      check("rst_car_req", bus.car_req, 1'b0);
      check("rst_conflict", bus.conflict, 1'b0);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      apply(bus.sensor_c, bus.out_h);
   endtask

   // Arms the light with sensor high, turns the highway red at step 0, drops the sensor at drop_at.
   task automatic green_trial(input int drop_at, output int g_len, output int y_len, output int first_g);
      g_len = 0; y_len = 0; first_g = -1;
      for (int i = 0; i < 10; i++) step(1'b1, 3'b001);
      for (int i = -1; i < 40; i++) begin
         step((i >= drop_at) ? 1'b0 : 1'b1, (i < 0) ? 3'b001 : 3'b100);
         @(posedge clk);
         #2;
         if (bus.out_c == 3'b001) begin
            g_len++;
            if (first_g < 0) first_g = i;
         end
         if (bus.out_c == 3'b010) y_len++;
      end
   endtask

   initial begin
      int       lat, seen, g, y, fg, cnt, rand_greens, found;
      int       hw, hw_left, red_age, run_left;
      bit       seen_green, s_lvl;
      logic [2:0] h;
      logic [2:0] odd[3];
      odd[0] = 3'b000; odd[1] = 3'b011; odd[2] = 3'b110;

      bus.sensor_c = 1'b0;
      bus.out_h    = 3'b001;
      model_reset();
      do_reset(1'b1);

      // idle highway green, no car
      for (int i = 0; i < 50; i++) step(1'b0, 3'b001);

      // clean step latency
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         step(1'b1, 3'b001);
         @(posedge clk);
         #2;
         if (bus.car_req) lat = i;
      end
      check("deb_latency", lat, 2 + DEB_LEN);
      for (int i = 0; i < 10; i++) step(1'b0, 3'b001);
      check("deb_fall", bus.car_req, 1'b0);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         step(i < 3, 3'b001);
         @(posedge clk);
         #2;
         if (bus.car_req) seen = 1;
      end
      check("glitch_ignored", seen, 0);

      green_trial(99, g, y, fg);
      check("max_green_len", g, MAX_G);
      check("yellow_len", y, Y_T);
      check("green_latency", fg, 0);
      green_trial(-1, g, y, fg);
      check("min_green_len", g, MIN_G);
      green_trial(2, g, y, fg);
      check("mid_green_len", g, 8);

      // randomized traffic with a well-behaved highway
      hw = 0; hw_left = 5; red_age = 0; seen_green = 0; run_left = 0; s_lvl = 0; rand_greens = 0;
      for (int n = 0; n < 1500; n++) begin
         if (run_left == 0) begin
            s_lvl    = 1'($urandom_range(0, 1));
            run_left = $urandom_range(1, 10);
         end
         run_left--;
         h = 3'b100;
         if (hw == 0) begin
            h = ($urandom_range(0, 6) == 0) ? odd[$urandom_range(0, 2)] : 3'b001;
            hw_left--;
            if (hw_left == 0) begin hw = 1; hw_left = 2; end
         end else if (hw == 1) begin
            h = 3'b010;
            hw_left--;
            if (hw_left == 0) hw = 2;
         end else begin
            if (m_phase != 0) seen_green = 1;
            red_age++;
            if ((seen_green && m_phase == 0 && $urandom_range(0, 2) == 0) || red_age > 200) begin
               hw = 0; hw_left = $urandom_range(1, 20); seen_green = 0; red_age = 0;
            end
         end
         step(s_lvl, h);
         if (m_phase == 1) rand_greens++;
      end
      check("random_greens_seen", rand_greens > 0, 1);

      // asynchronous reset in the middle of yellow
      do_reset(1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 3'b001);
      found = 0;
      for (int i = 0; i < 30 && found == 0; i++) begin
         step(1'b0, 3'b100);
         @(posedge clk);
         #1;
         if (bus.out_c == 3'b010) found = 1;
      end
      check("reached_yellow", found, 1);
      do_reset(1'b0);
      green_trial(99, g, y, fg);
      check("post_reset_green", g, MAX_G);

      // conflict during green is sticky
      for (int i = 0; i < 10; i++) step(1'b1, 3'b001);
      for (int i = 0; i < 4; i++) step(1'b1, 3'b100);
      step(1'b1, 3'b001);
      @(posedge clk);
      #2;
      check("conflict_out_c", bus.out_c, 3'b100);
      check("conflict_set", bus.conflict, 1'b1);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, (i < 10) ? 3'b001 : 3'b100);
         @(posedge clk);
         #2;
         if (bus.out_c != 3'b100) cnt++;
      end
      check("conflict_no_green", cnt, 0);
      check("conflict_sticky", bus.conflict, 1'b1);

      @(posedge clk);
      #2;
      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
